// File: rtl/bicubic_line_buffer.sv
// rtl/bicubic_line_buffer.sv - three-line rotating buffer presenting 4-pixel vertical columns
// Feeds the bicubic core one column per accepted pixel once three full lines are stored.
module bicubic_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  localparam int CW = $clog2(IMG_WIDTH),
  localparam int LW = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  input  logic                  sof,
  output logic [DATA_WIDTH-1:0] row0_out,
  output logic [DATA_WIDTH-1:0] row1_out,
  output logic [DATA_WIDTH-1:0] row2_out,
  output logic [DATA_WIDTH-1:0] row3_out,
  output logic                  out_valid,
  output logic [CW-1:0]         out_col,
  output logic [LW-1:0]         out_line,
  output logic                  frame_done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [DATA_WIDTH-1:0] mem [0:2][0:IMG_WIDTH-1];

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [LW-1:0]         line_q, line_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] row0_q, row0_d, row1_q, row1_d, row2_q, row2_d, row3_q, row3_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [CW-1:0]         out_col_q, out_col_d;
  logic [LW-1:0]         out_line_q, out_line_d;

  logic                  start, accept, last_col, last_line;
  logic [1:0]            e_state, e_ptr, ptr1, ptr2;
  logic [CW-1:0]         e_col;
  logic [LW-1:0]         e_line;

  // A qualified sof restarts the frame in the same cycle, so the pixel is handled as (0,0).
  always_comb begin
    start     = pix_valid & sof;
    accept    = pix_valid & (start | (state_q != ST_IDLE));
    e_state   = start ? ST_FILL : state_q;
    e_col     = start ? '0 : col_q;
    e_line    = start ? '0 : line_q;
    e_ptr     = start ? 2'd0 : ptr_q;
    ptr1      = (e_ptr == 2'd2) ? 2'd0 : e_ptr + 2'd1;
    ptr2      = (e_ptr == 2'd0) ? 2'd2 : e_ptr - 2'd1;
    last_col  = (e_col == CW'(IMG_WIDTH - 1));
    last_line = (e_line == LW'(IMG_HEIGHT - 1));
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    line_d       = line_q;
    ptr_d        = ptr_q;
    row0_d       = row0_q;
    row1_d       = row1_q;
    row2_d       = row2_q;
    row3_d       = row3_q;
    out_col_d    = out_col_q;
    out_line_d   = out_line_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (accept) begin
      state_d = e_state;
      col_d   = e_col + 1'b1;
      line_d  = e_line;
      ptr_d   = e_ptr;
      if (last_col) begin
        col_d  = '0;
        line_d = e_line + 1'b1;
        ptr_d  = ptr1;
        if (e_state == ST_FILL && e_line == LW'(2)) state_d = ST_STREAM;
        if (e_state == ST_STREAM && last_line) begin
          state_d = ST_IDLE;
          line_d  = '0;
          ptr_d   = 2'd0;
        end
      end
      if (e_state == ST_STREAM) begin
        out_valid_d  = 1'b1;
        frame_done_d = last_col & last_line;
        row0_d       = mem[e_ptr][e_col];
        row1_d       = mem[ptr1][e_col];
        row2_d       = mem[ptr2][e_col];
        row3_d       = pix_in;
        out_col_d    = e_col;
        out_line_d   = e_line;
      end
    end
  end

  // The combinational read above sees the pre-write value, giving read-before-write on row0.
  always_ff @(posedge clk) begin
    if (accept) mem[e_ptr][e_col] <= pix_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      line_q       <= '0;
      ptr_q        <= 2'd0;
      row0_q       <= '0;
      row1_q       <= '0;
      row2_q       <= '0;
      row3_q       <= '0;
      out_col_q    <= '0;
      out_line_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      ptr_q        <= ptr_d;
      row0_q       <= row0_d;
      row1_q       <= row1_d;
      row2_q       <= row2_d;
      row3_q       <= row3_d;
      out_col_q    <= out_col_d;
      out_line_q   <= out_line_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row0_out   = row0_q;
  assign row1_out   = row1_q;
  assign row2_out   = row2_q;
  assign row3_out   = row3_q;
  assign out_col    = out_col_q;
  assign out_line   = out_line_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/bicubic_line_buffer.md
Name: bicubic_line_buffer

Overview:
- Upstream feeder for the bicubic interpolation core.
- Accepts a raster-scan pixel stream, one pixel per cycle, and stores the three previous image lines in rotating line memories.
- Each cycle it presents a vertical 4-pixel column (lines n-3, n-2, n-1, n) at the same column index. The core's horizontal shift window builds the 4x4 neighbourhood from these columns.
- Also emits column/line coordinates, which downstream phase/weight logic uses.

Parameters:
- DATA_WIDTH, 8: pixel bit width.
- IMG_WIDTH, 640: pixels per line; must be >= 4.
- IMG_HEIGHT, 480: lines per frame; must be >= 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pix_in  in  DATA_WIDTH  input pixel.
- pix_valid  in  1  pix_in is valid this cycle.
- sof  in  1  start of frame; qualified by pix_valid and marks pixel (0,0).
- row0_out  out  DATA_WIDTH  pixel from line n-3 (oldest).
- row1_out  out  DATA_WIDTH  pixel from line n-2.
- row2_out  out  DATA_WIDTH  pixel from line n-1.
- row3_out  out  DATA_WIDTH  pixel from line n (current input).
- out_valid  out  1  row0..row3_out form a valid column.
- out_col  out  $clog2(IMG_WIDTH)  column index of the presented column.
- out_line  out  $clog2(IMG_HEIGHT)  line index n of row3_out.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (async, rst=1): all outputs 0; col/line counters 0; slot pointer old_ptr=0; FSM=IDLE. Line memory contents are not cleared.
- No backpressure. Every pix_valid cycle is consumed; the core has no stall.
- Storage: three line memories (slots 0..2), each IMG_WIDTH x DATA_WIDTH. old_ptr selects the slot holding line n-3.
- Per accepted pixel at column c:
  - row0 <= mem[old_ptr][c]
  - row1 <= mem[(old_ptr+1)%3][c]
  - row2 <= mem[(old_ptr+2)%3][c]
  - row3 <= pix_in
  - then mem[old_ptr][c] <= pix_in. This is read-before-write at the same address and the same edge; the old value must appear on row0.
- Latency: outputs are registered, one cycle after acceptance.
- Counters:
  - col increments per accepted pixel.
  - At col==IMG_WIDTH-1: col wraps to 0, line increments, old_ptr <= (old_ptr+1)%3.
- FSM:
  - IDLE: pixels without sof are discarded, no memory write. pix_valid&sof -> FILL; that pixel is processed as (0,0).
  - FILL: lines 0..2; memories are written; out_valid=0. Last pixel of line 2 -> STREAM.
  - STREAM: lines 3..IMG_HEIGHT-1; out_valid=1 one cycle after each accepted pixel. Last pixel of line IMG_HEIGHT-1 -> IDLE.
- Pulse timing:
  - frame_done=1 in the same cycle as the final out_valid.
  - out_valid is 0 in any cycle without an accepted pixel the previous cycle.
- out_col/out_line: registered together with row*_out and equal the counters at acceptance. They hold their value when out_valid=0.
- sof mid-frame (pix_valid&sof while in FILL/STREAM): abort the current frame with no frame_done pulse. Counters reset, old_ptr=0, FSM=FILL, and the pixel is processed as (0,0).
- sof asserted with pix_valid=0 is ignored.
- Reset mid-frame: immediate return to the reset state. The next frame requires sof.
- Pixel gaps (pix_valid=0) inside a line are legal. State holds and nothing is emitted.

Test Plan:
- Setup: IMG_WIDTH=4, IMG_HEIGHT=6, pixel value = 16*line+col.
- Full frame, continuous valid -> out_valid asserted for exactly 12 cycles. The first column is (row0..3)=(0x00,0x10,0x20,0x30), out_col=0, out_line=3. The column at line 5, col 3 is (0x23,0x33,0x43,0x53). frame_done pulses once, together with it.
- Same frame with pix_valid toggled 1/0 every cycle -> identical output sequence, out_valid interleaved with 0s, no duplicates.
- Pixels before sof, then a full frame -> the leading pixels are ignored and the outputs match the continuous case.
- sof reissued at line 4 col 2, then a full frame -> no frame_done for the aborted frame. The new frame's first valid column is (0x00,0x10,0x20,0x30) at line 3.
- rst asserted mid-STREAM -> all outputs 0 asynchronously, before the next clk edge. Post-reset pixels without sof produce no out_valid.
- Back-to-back frames, second frame value = 0x80+16*line+col -> second frame outputs contain no first-frame data and old_ptr wraps correctly; the first column is (0x80,0x90,0xA0,0xB0).
